// File: rtl/regfile_write_ctrl_if.sv
// -----------------------------------------------------------------------------
// regfile_write_ctrl_if
//   Bundles the two writeback requester handshakes and the registered
//   register-file write port driven by regfile_write_ctrl.
//
//   master : requester / register-file side (drives valid/addr/data,
//            observes ready and the write port)
//   slave  : the write controller (observes requests, drives ready and
//            the write port)
//
//   r0_*   : requester 0 (ALU writeback)  valid/addr/data in, ready out
//   r1_*   : requester 1 (load unit)      valid/addr/data in, ready out
//   wen    : register file write enable
//   wsel   : register file write select
//   wdata  : register file write data (drives the register file "in" port)
// -----------------------------------------------------------------------------
interface regfile_write_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  logic              r0_valid;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_data;
  logic              r0_ready;

  logic              r1_valid;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_data;
  logic              r1_ready;

  logic              wen;
  logic [ADDR_W-1:0] wsel;
  logic [DATA_W-1:0] wdata;

  modport master (
    output r0_valid, r0_addr, r0_data,
    output r1_valid, r1_addr, r1_data,
    input  r0_ready, r1_ready,
    input  wen, wsel, wdata
  );

  modport slave (
    input  r0_valid, r0_addr, r0_data,
    input  r1_valid, r1_addr, r1_data,
    output r0_ready, r1_ready,
    output wen, wsel, wdata
  );

endinterface

// File: rtl/regfile_write_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_write_ctrl
//   Sequencer and write-port arbiter for the 32 x 32 register file.
//   Out of reset (or after a clear request) it sweeps every register and
//   writes zero, then shares the single write port between two writeback
//   requesters with a valid/ready handshake and round-robin priority.
//   All write-port outputs are registered; readies are combinational.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   INIT  | zero sweep, one register per cycle, readies held low
//   RUN   | arbitrate r0/r1, one write issued the cycle after each accept
//
// Ports:
//   clk        system clock, all state on rising edge
//   reset      asynchronous active-low reset
//   clear      synchronous request (RUN only) to re-run the zero sweep
//   bus        requester handshakes + registered write port (slave modport)
//   init_done  high while RUN is active, after the sweep has completed
//   stall_cnt  saturating count of RUN cycles with a waiting requester
// -----------------------------------------------------------------------------
module regfile_write_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  regfile_write_ctrl_if.slave  bus,
  output logic                 init_done,
  output logic [CNT_W-1:0]     stall_cnt
);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NREG - 1);
  localparam logic [CNT_W-1:0]  STALL_MAX = '1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                prio_q, prio_d;
  logic                wen_q, wen_d;
  logic [ADDR_W-1:0]   wsel_q, wsel_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                init_done_q, init_done_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic                r0_rdy;
  logic                r1_rdy;
  logic                stalled;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      prio_q      <= 1'b0;
      wen_q       <= 1'b0;
      wsel_q      <= '0;
      wdata_q     <= '0;
      init_done_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prio_q      <= prio_d;
      wen_q       <= wen_d;
      wsel_q      <= wsel_d;
      wdata_q     <= wdata_d;
      init_done_q <= init_done_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prio_d      = prio_q;
    wen_d       = 1'b0;
    wsel_d      = wsel_q;
    wdata_d     = wdata_q;
    init_done_d = init_done_q;
    stall_cnt_d = stall_cnt_q;
    r0_rdy      = 1'b0;
    r1_rdy      = 1'b0;
    stalled     = 1'b0;

    case (state_q)
      INIT: begin
        // One zero write per cycle; clear and requesters are ignored here.
        wen_d   = 1'b1;
        wsel_d  = cnt_q;
        wdata_d = '0;
        if (cnt_q == LAST_IDX) begin
          cnt_d       = '0;
          state_d     = RUN;
          init_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end

      RUN: begin
        // prio names the requester that wins when both are valid.
        r0_rdy = bus.r0_valid & ~clear & (~bus.r1_valid | ~prio_q);
        r1_rdy = bus.r1_valid & ~clear & (~bus.r0_valid |  prio_q);

        stalled = (bus.r0_valid & ~r0_rdy) | (bus.r1_valid & ~r1_rdy);
        if (stalled && (stall_cnt_q != STALL_MAX)) begin
          stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        if (clear) begin
          state_d     = INIT;
          cnt_d       = '0;
          init_done_d = 1'b0;
        end else if (r0_rdy) begin
          wen_d   = 1'b1;
          wsel_d  = bus.r0_addr;
          wdata_d = bus.r0_data;
          prio_d  = 1'b1;
        end else if (r1_rdy) begin
          wen_d   = 1'b1;
          wsel_d  = bus.r1_addr;
          wdata_d = bus.r1_data;
          prio_d  = 1'b0;
        end
      end

      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.r0_ready = r0_rdy;
  assign bus.r1_ready = r1_rdy;
  assign bus.wen      = wen_q;
  assign bus.wsel     = wsel_q;
  assign bus.wdata    = wdata_q;
  assign init_done    = init_done_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_ctrl
//   Self-checking bench for regfile_write_ctrl. A behavioural model (sweep
//   index, round-robin winner, expected register contents) predicts every
//   cycle; a small register-file array captures the DUT's write port so the
//   final register contents can be compared against the model.
// -----------------------------------------------------------------------------
module tb_regfile_write_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;
  localparam int CNT_W  = 8;
  localparam int SMAX   = (1 << CNT_W) - 1;

  logic clk;
  logic reset;
  logic clear;
  logic init_done;
  logic [CNT_W-1:0] stall_cnt;

  regfile_write_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_if ();

  regfile_write_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG), .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .bus       (bus_if),
    .init_done (init_done),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file fed by the DUT's write port.
  logic [DATA_W-1:0] rf [NREG];
  always @(posedge clk) begin
    if (bus_if.wen) rf[bus_if.wsel] <= bus_if.wdata;
  end

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit               m_run;
  int               m_idx;
  int               m_prio;
  int               m_stall;
  bit               m_wen;
  int               m_wsel;
  logic [DATA_W-1:0] m_wdata;
  bit               m_done;
  logic [DATA_W-1:0] m_regs [NREG];
  bit               g0, g1;   // grants predicted for the last cycle

  task automatic model_reset();
    m_run = 0; m_idx = 0; m_prio = 0; m_stall = 0;
    m_wen = 0; m_wsel = 0; m_wdata = '0; m_done = 0;
  endtask

  task automatic set_idle();
    clear = 0;
    bus_if.r0_valid = 0; bus_if.r0_addr = '0; bus_if.r0_data = '0;
    bus_if.r1_valid = 0; bus_if.r1_addr = '0; bus_if.r1_data = '0;
  endtask

  // One clock cycle: entered just after a falling edge with inputs applied,
  // predicts readies and the registered outputs, returns after the next
  // falling edge.
  task automatic tick();
    int grant;
    bit v0, v1;
    #1;
    v0 = bus_if.r0_valid;
    v1 = bus_if.r1_valid;
    grant = -1;
    if (m_run && !clear) begin
      if (v0 && v1)  grant = m_prio;
      else if (v0)   grant = 0;
      else if (v1)   grant = 1;
    end
    g0 = (grant == 0);
    g1 = (grant == 1);
    checks++;
    if (bus_if.r0_ready !== g0) begin
      errors++;
      $display("FAIL r0_ready: got %b expected %b at %0t", bus_if.r0_ready, g0, $time);
    end
    checks++;
    if (bus_if.r1_ready !== g1) begin
      errors++;
      $display("FAIL r1_ready: got %b expected %b at %0t", bus_if.r1_ready, g1, $time);
    end

    if (m_run && ((v0 && grant != 0) || (v1 && grant != 1)) && m_stall < SMAX)
      m_stall++;
    if (!m_run) begin
      m_wen = 1; m_wsel = m_idx; m_wdata = '0; m_regs[m_idx] = '0;
      m_idx++;
      if (m_idx == NREG) begin m_run = 1; m_done = 1; m_idx = 0; end
    end else if (clear) begin
      m_run = 0; m_idx = 0; m_done = 0; m_wen = 0;
    end else if (grant == 0) begin
      m_wen = 1; m_wsel = int'(bus_if.r0_addr); m_wdata = bus_if.r0_data;
      m_regs[m_wsel] = m_wdata; m_prio = 1;
    end else if (grant == 1) begin
      m_wen = 1; m_wsel = int'(bus_if.r1_addr); m_wdata = bus_if.r1_data;
      m_regs[m_wsel] = m_wdata; m_prio = 0;
    end else begin
      m_wen = 0;
    end

    @(posedge clk);
    #1;
    checks++;
    if (bus_if.wen !== m_wen) begin
      errors++;
      $display("FAIL wen: got %b expected %b at %0t", bus_if.wen, m_wen, $time);
    end
    checks++;
    if (int'(bus_if.wsel) != m_wsel || $isunknown(bus_if.wsel)) begin
      errors++;
      $display("FAIL wsel: got %0d expected %0d at %0t", bus_if.wsel, m_wsel, $time);
    end
    checks++;
    if (bus_if.wdata !== m_wdata) begin
      errors++;
      $display("FAIL wdata: got %h expected %h at %0t", bus_if.wdata, m_wdata, $time);
    end
    checks++;
    if (init_done !== m_done) begin
      errors++;
      $display("FAIL init_done: got %b expected %b at %0t", init_done, m_done, $time);
    end
    checks++;
    if (int'(stall_cnt) != m_stall || $isunknown(stall_cnt)) begin
      errors++;
      $display("FAIL stall_cnt: got %0d expected %0d at %0t", stall_cnt, m_stall, $time);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    int nwen;
    set_idle();
    reset = 0;
    model_reset();
    #1;
    checks++;
    if (bus_if.wen !== 1'b0 || init_done !== 1'b0 || stall_cnt !== '0 ||
        bus_if.wsel !== '0 || bus_if.wdata !== '0) begin
      errors++;
      $display("FAIL reset_values: got wen=%b done=%b stall=%0d wsel=%0d wdata=%h expected all zero",
               bus_if.wen, init_done, stall_cnt, bus_if.wsel, bus_if.wdata);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (bus_if.r0_ready !== 1'b0 || bus_if.r1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b%b expected 00", bus_if.r0_ready, bus_if.r1_ready);
    end
    reset = 1;
    // Requesters active during the sweep must be ignored.
    bus_if.r0_valid = 1; bus_if.r0_addr = 5'd4; bus_if.r0_data = 32'h1234;
    nwen = 0;
    for (int i = 0; i < NREG; i++) begin
      tick();
      if (bus_if.wen === 1'b1) nwen++;
    end
    checks++;
    if (nwen != NREG) begin
      errors++;
      $display("FAIL sweep_len: got %0d expected %0d", nwen, NREG);
    end
    set_idle();
    repeat (2) tick();
  endtask

  task automatic test_r0_only();
    bus_if.r0_valid = 1; bus_if.r0_addr = 5'd8; bus_if.r0_data = 32'h8888;
    tick();
    checks++;
    if (!g0) begin
      errors++;
      $display("FAIL r0_only_grant: got %b expected 1", g0);
    end
    set_idle();
    repeat (3) tick();
    checks++;
    if (rf[8] !== 32'h8888) begin
      errors++;
      $display("FAIL r0_only_read: got %h expected 00008888", rf[8]);
    end
  endtask

  // Present both requests continuously; each drops its valid once granted.
  task automatic run_pair(input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                          input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                          output int first_sel, output int second_sel);
    int n;
    first_sel = -1; second_sel = -1;
    bus_if.r0_valid = 1; bus_if.r0_addr = a0; bus_if.r0_data = d0;
    bus_if.r1_valid = 1; bus_if.r1_addr = a1; bus_if.r1_data = d1;
    n = 0;
    while ((bus_if.r0_valid || bus_if.r1_valid) && n < 10) begin
      tick();
      if (bus_if.wen === 1'b1) begin
        if (first_sel < 0) first_sel = int'(bus_if.wsel);
        else second_sel = int'(bus_if.wsel);
      end
      if (g0) bus_if.r0_valid = 0;
      if (g1) bus_if.r1_valid = 0;
      n++;
    end
    checks++;
    if (n >= 10) begin
      errors++;
      $display("FAIL pair_timeout: got %0d cycles expected under 10", n);
    end
    set_idle();
  endtask

  task automatic test_contention();
    int s1, s2;
    // r1-only write leaves priority with requester 0.
    bus_if.r1_valid = 1; bus_if.r1_addr = 5'd1; bus_if.r1_data = $urandom;
    tick();
    set_idle();
    tick();
    run_pair(5'd3, 32'h3333, 5'd7, 32'h7777, s1, s2);
    checks++;
    if (s1 != 3 || s2 != 7) begin
      errors++;
      $display("FAIL contention_order: got %0d,%0d expected 3,7", s1, s2);
    end
  endtask

  task automatic test_same_addr();
    int s1, s2;
    // r0-only write hands priority to requester 1.
    bus_if.r0_valid = 1; bus_if.r0_addr = 5'd2; bus_if.r0_data = $urandom;
    tick();
    set_idle();
    tick();
    run_pair(5'd9, 32'h9999, 5'd9, 32'h5A5A, s1, s2);
    repeat (2) tick();
    checks++;
    if (rf[9] !== 32'h9999) begin
      errors++;
      $display("FAIL same_addr_read: got %h expected 00009999", rf[9]);
    end
  endtask

  task automatic test_clear();
    int n;
    bus_if.r0_valid = 1; bus_if.r0_addr = 5'd12; bus_if.r0_data = 32'hC1EA;
    clear = 1;
    tick();
    clear = 0;
    checks++;
    if (init_done !== 1'b0) begin
      errors++;
      $display("FAIL clear_done: got %b expected 0", init_done);
    end
    n = 0;
    while (!g0 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != NREG + 1) begin
      errors++;
      $display("FAIL clear_grant_delay: got %0d expected %0d", n, NREG + 1);
    end
    set_idle();
    repeat (2) tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if (!bus_if.r0_valid && $urandom_range(0, 2) != 0) begin
        bus_if.r0_valid = 1; bus_if.r0_addr = ADDR_W'($urandom); bus_if.r0_data = $urandom;
      end
      if (!bus_if.r1_valid && $urandom_range(0, 2) != 0) begin
        bus_if.r1_valid = 1; bus_if.r1_addr = ADDR_W'($urandom); bus_if.r1_data = $urandom;
      end
      clear = ($urandom_range(0, 79) == 0);
      tick();
      if (g0) bus_if.r0_valid = 0;
      if (g1) bus_if.r1_valid = 0;
    end
    set_idle();
    repeat (2) tick();
  endtask

  task automatic test_reset_mid_sweep();
    clear = 1;
    tick();
    clear = 0;
    repeat (10) tick();
    reset = 0;
    model_reset();
    #1;
    checks++;
    if (bus_if.wen !== 1'b0 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_sweep_reset: got wen=%b done=%b expected 0 0", bus_if.wen, init_done);
    end
    repeat (2) @(negedge clk);
    reset = 1;
    tick();
    checks++;
    if (bus_if.wsel !== '0 || bus_if.wen !== 1'b1) begin
      errors++;
      $display("FAIL sweep_restart: got wsel=%0d wen=%b expected 0 1", bus_if.wsel, bus_if.wen);
    end
    repeat (NREG - 1) tick();
  endtask

  task automatic test_stall_sat();
    bus_if.r0_valid = 1; bus_if.r0_addr = ADDR_W'($urandom); bus_if.r0_data = $urandom;
    bus_if.r1_valid = 1; bus_if.r1_addr = ADDR_W'($urandom); bus_if.r1_data = $urandom;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (g0) begin bus_if.r0_addr = ADDR_W'($urandom); bus_if.r0_data = $urandom; end
      if (g1) begin bus_if.r1_addr = ADDR_W'($urandom); bus_if.r1_data = $urandom; end
    end
    checks++;
    if (stall_cnt !== 8'd255) begin
      errors++;
      $display("FAIL stall_saturate: got %0d expected 255", stall_cnt);
    end
    set_idle();
    repeat (3) tick();
  endtask

  task automatic test_final_contents();
    for (int r = 0; r < NREG; r++) begin
      checks++;
      if (rf[r] !== m_regs[r]) begin
        errors++;
        $display("FAIL reg_contents R%0d: got %h expected %h", r, rf[r], m_regs[r]);
      end
    end
  endtask

  initial begin
    reset = 0;
    set_idle();
    @(negedge clk);
    test_reset();
    test_r0_only();
    test_contention();
    test_same_addr();
    test_clear();
    test_random();
    test_reset_mid_sweep();
    test_stall_sat();
    test_final_contents();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
